// File: rtl/sram_port_arbiter.sv
// Shares one SRAM read/write port among NUM_REQ requestors; ack and read data return one cycle after issue.
// Define SRAM_ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration instead of round-robin.
module sram_port_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 12,
    parameter int REQ_ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            ack,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic [ADDR_WIDTH-1:0]         sram_addr,
    output logic                          sram_we,
    output logic [DATA_WIDTH-1:0]         sram_wdata,
    input  logic [DATA_WIDTH-1:0]         sram_q
);

    logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0]      ack_mask;
    logic [NUM_REQ-1:0]      elig;
    logic                    win_vld;
    logic [REQ_ID_WIDTH-1:0] win_id;
    logic                    issue_vld;
    logic                    pend_vld_p1;
    logic [REQ_ID_WIDTH-1:0] pend_id_p1;

    function automatic logic [NUM_REQ-1:0] id_onehot(input logic [REQ_ID_WIDTH-1:0] id);
        id_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (id == REQ_ID_WIDTH'(i)) begin
                id_onehot[i] = 1'b1;
            end
        end
    endfunction

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // The requestor being acked still holds its old request; masking it avoids a duplicate issue.
    assign ack_mask = pend_vld_p1 ? id_onehot(pend_id_p1) : '0;
    assign elig     = req & ~ack_mask;

    // Stage p0: pick a winner among eligible requestors
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
    always_comb begin : fp_pick
        win_vld = 1'b0;
        win_id  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_vld && elig[i]) begin
                win_vld = 1'b1;
                win_id  = REQ_ID_WIDTH'(i);
            end
        end
    end
`else
    logic [REQ_ID_WIDTH-1:0] last_grant;

    always_comb begin : rr_pick
        int                      cand;
        logic [REQ_ID_WIDTH-1:0] cand_id;
        win_vld = 1'b0;
        win_id  = '0;
        cand    = 0;
        cand_id = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand    = (int'(last_grant) + i) % NUM_REQ;
            cand_id = REQ_ID_WIDTH'(cand);
            if (!win_vld && elig[cand_id]) begin
                win_vld = 1'b1;
                win_id  = cand_id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_grant <= REQ_ID_WIDTH'(NUM_REQ - 1);
        end else if (win_vld) begin
            last_grant <= win_id;
        end
    end
`endif

    // Nothing reaches the SRAM while reset is asserted.
    assign issue_vld = win_vld & reset_n;

    always_comb begin
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (issue_vld) begin
            sram_we    = req_we[win_id];
            sram_addr  = addr_arr[win_id];
            sram_wdata = wdata_arr[win_id];
        end
    end

    // Stage p1: response cycle, SRAM registered output lines up with the pending grant
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_vld_p1 <= 1'b0;
        end else begin
            pend_vld_p1 <= win_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (issue_vld) begin
            pend_id_p1 <= win_id;
        end
    end

    assign ack   = ack_mask;
    assign rdata = sram_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed vector table, corner sequences and a randomized run against a reference model.
module tb_sram_port_arbiter;
    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N-1:0]      req, req_we;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      ack;
    logic [DW-1:0]     rdata, sram_wdata, sram_q;
    logic [AW-1:0]     sram_addr;
    logic              sram_we;

    always #5 clk = ~clk;

    sram_port_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .rdata(rdata),
        .sram_addr(sram_addr), .sram_we(sram_we), .sram_wdata(sram_wdata), .sram_q(sram_q)
    );

    // Write-through SRAM port with registered output
    logic [DW-1:0] sram_mem [1<<AW];
    initial for (int i = 0; i < (1<<AW); i++) sram_mem[i] = '0;
    always @(posedge clk) begin
        if (sram_we) begin
            sram_mem[sram_addr] <= sram_wdata;
            sram_q              <= sram_wdata;
        end else begin
            sram_q <= sram_mem[sram_addr];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [N-1:0] r, input logic [N-1:0] we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req    = r;
        req_we = we;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = a;
            req_wdata[i*DW +: DW] = d;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        set_all('0, '0, '0, '0);
        tick();
        @(negedge clk);
        check("rst_we", sram_we, 0);
        tick();
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0]  req;
        logic [N-1:0]  we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wdata;
        logic [N-1:0]  exp_ack;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [9];

    // Reference model state for the randomized run
    int            m_last;
    bit            m_pvld;
    int            m_pid;
    logic [DW-1:0] m_pdata;
    logic [DW-1:0] ref_mem [16];
    bit            a_req [N];
    bit            a_we  [N];
    int            a_off [N];
    logic [DW-1:0] a_wd  [N];

    function automatic int pick(input logic [N-1:0] e, input int last);
        int best  = -1;
        int bestd = N;
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
        for (int i = N - 1; i >= 0; i--) if (e[i]) best = i;
`else
        for (int i = 0; i < N; i++) begin
            int d = (i - last - 1 + 2*N) % N;
            if (e[i] && d < bestd) begin
                bestd = d;
                best  = i;
            end
        end
`endif
        return best;
    endfunction

    task automatic new_req(input int i);
        a_req[i] = 1'b1;
        a_we[i]  = $urandom_range(0, 1) == 1;
        a_off[i] = $urandom_range(0, 15);
        a_wd[i]  = DW'($urandom);
    endtask

    initial begin
        vecs[0] = '{4'b0001, 4'b0001, 12'h010, 16'hBEEF, 1'b1, 12'h010, 16'hBEEF, 4'b0000, 16'h0000};
        vecs[1] = '{4'b0001, 4'b0001, 12'h010, 16'hBEEF, 1'b0, 12'h000, 16'h0000, 4'b0001, 16'hBEEF};
        vecs[2] = '{4'b0010, 4'b0000, 12'h010, 16'h0000, 1'b0, 12'h010, 16'h0000, 4'b0000, 16'h0000};
        vecs[3] = '{4'b0010, 4'b0000, 12'h010, 16'h0000, 1'b0, 12'h000, 16'h0000, 4'b0010, 16'hBEEF};
        vecs[4] = '{4'b0000, 4'b0000, 12'h000, 16'h0000, 1'b0, 12'h000, 16'h0000, 4'b0000, 16'h0000};
        vecs[5] = '{4'b1000, 4'b1000, 12'h020, 16'h1234, 1'b1, 12'h020, 16'h1234, 4'b0000, 16'h0000};
        vecs[6] = '{4'b1010, 4'b1000, 12'h020, 16'h1234, 1'b0, 12'h020, 16'h1234, 4'b1000, 16'h1234};
        vecs[7] = '{4'b0010, 4'b0000, 12'h020, 16'h1234, 1'b0, 12'h000, 16'h0000, 4'b0010, 16'h1234};
        vecs[8] = '{4'b0000, 4'b0000, 12'h000, 16'h0000, 1'b0, 12'h000, 16'h0000, 4'b0000, 16'h0000};

        do_reset();

        // Directed table
        for (int v = 0; v < 9; v++) begin
            set_all(vecs[v].req, vecs[v].we, vecs[v].addr, vecs[v].wdata);
            @(negedge clk);
            check($sformatf("tbl%0d_we", v), sram_we, vecs[v].exp_we);
            check($sformatf("tbl%0d_addr", v), sram_addr, vecs[v].exp_addr);
            check($sformatf("tbl%0d_wdata", v), sram_wdata, vecs[v].exp_wdata);
            check($sformatf("tbl%0d_ack", v), ack, vecs[v].exp_ack);
            if (vecs[v].exp_ack != '0) check($sformatf("tbl%0d_rdata", v), rdata, vecs[v].exp_rdata);
            tick();
        end

`ifndef SRAM_ARB_FIXED_PRIORITY_EN
        // All four requesting continuously: strict rotation, one ack per cycle
        do_reset();
        req = 4'b1111;
        req_we = 4'b0000;
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(12'h100 + i);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("rr%0d_addr", k), sram_addr, 12'h100 + (k % 4));
            check($sformatf("rr%0d_ack", k), ack, (k == 0) ? 0 : (1 << ((k - 1) % 4)));
            tick();
        end
`else
        // Fixed priority with 1 and 2 held: masking alternates them; 0 then wins the next free slot
        do_reset();
        req = 4'b0110;
        req_we = 4'b0000;
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(12'h100 + i);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("fp%0d_addr", k), sram_addr, (k % 2 == 0) ? 12'h101 : 12'h102);
            tick();
        end
        req = 4'b0111;
        @(negedge clk);
        check("fp_req0_addr", sram_addr, 12'h100);
        check("fp_req0_ack", ack, 4'b0100);
        tick();
`endif

        // Single requestor 2 re-presenting after every ack: issues only every second cycle
        do_reset();
        begin
            int n = 0;
            req = 4'b0100;
            req_we = 4'b0100;
            req_addr[2*AW +: AW]  = 12'h300;
            req_wdata[2*DW +: DW] = 16'hA000;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (k % 2 == 0) begin
                    check($sformatf("s2_%0d_we", k), sram_we, 1);
                    check($sformatf("s2_%0d_addr", k), sram_addr, 12'h300 + n);
                    check($sformatf("s2_%0d_ack", k), ack, 0);
                    tick();
                end else begin
                    check($sformatf("s2_%0d_we", k), sram_we, 0);
                    check($sformatf("s2_%0d_ack", k), ack, 4'b0100);
                    check($sformatf("s2_%0d_rdata", k), rdata, 16'hA000 + n);
                    tick();
                    n++;
                    req_addr[2*AW +: AW]  = AW'(12'h300 + n);
                    req_wdata[2*DW +: DW] = DW'(16'hA000 + n);
                end
            end
        end

        // Reset sampled in the same cycle as an issue: the request is dropped
        set_all(4'b0010, 4'b0000, 12'h010, 16'h0000);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_we0", sram_we, 0);
        tick();
        @(negedge clk);
        check("mid_rst_we1", sram_we, 0);
        check("mid_rst_ack1", ack, 0);
        tick();
        reset_n = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(12'h100 + i);
        @(negedge clk);
        check("post_rst_ack", ack, 0);
        check("post_rst_addr", sram_addr, 12'h100);
        tick();

        // Randomized traffic against the reference model
        do_reset();
        m_last = N - 1;
        m_pvld = 1'b0;
        m_pid  = 0;
        m_pdata = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        for (int i = 0; i < N; i++) a_req[i] = 1'b0;
        for (int c = 0; c < 600; c++) begin
            logic [N-1:0] rv, ev, exp_ack;
            int w;
            rv = '0;
            for (int i = 0; i < N; i++) begin
                rv[i] = a_req[i];
                req_we[i] = a_we[i];
                req_addr[i*AW +: AW]  = AW'(12'h200 + a_off[i]);
                req_wdata[i*DW +: DW] = a_wd[i];
            end
            req = rv;
            ev = rv;
            if (m_pvld) ev[m_pid] = 1'b0;
            w = pick(ev, m_last);
            exp_ack = '0;
            if (m_pvld) exp_ack[m_pid] = 1'b1;
            @(negedge clk);
            check("rnd_ack", ack, exp_ack);
            if (m_pvld) check("rnd_rdata", rdata, m_pdata);
            if (w >= 0) begin
                check("rnd_we", sram_we, a_we[w]);
                check("rnd_addr", sram_addr, 12'h200 + a_off[w]);
                check("rnd_wdata", sram_wdata, a_wd[w]);
                m_pdata = a_we[w] ? a_wd[w] : ref_mem[a_off[w]];
                if (a_we[w]) ref_mem[a_off[w]] = a_wd[w];
                m_pvld = 1'b1;
                m_pid  = w;
                m_last = w;
            end else begin
                check("rnd_idle_we", sram_we, 0);
                check("rnd_idle_addr", sram_addr, 0);
                m_pvld = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (exp_ack[i]) begin
                    if ($urandom_range(0, 1) == 1) new_req(i);
                    else a_req[i] = 1'b0;
                end else if (!a_req[i] && $urandom_range(0, 2) == 0) begin
                    new_req(i);
                end
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Round-robin arbiter that lets NUM_REQ core-side requestors share one read/write port of the team's dual-ported SRAM.
- Sits directly upstream of the SRAM port: it drives the port's address, write-enable and write data, then captures the port's registered read data.
- Returns that data, with a one-cycle ack, to the requestor that won arbitration.
- Typical use: two instances, one per SRAM port, each serving a cluster of cores.

Parameters:
- NUM_REQ, 4, number of requestors (2..8).
- DATA_WIDTH, 16, data word width; must match the SRAM.
- ADDR_WIDTH, 12, word address width; must match the SRAM.
- REQ_ID_WIDTH, $clog2(NUM_REQ), width of the internal grant index.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  per-requestor request, level; held until acked.
- req_we  in  NUM_REQ  per-requestor write flag; valid while req is high.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requestor i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data, sliced the same way.
- ack  out  NUM_REQ  one-hot completion pulse.
- rdata  out  DATA_WIDTH  response data, shared by all requestors; valid only with an ack bit.
- sram_addr  out  ADDR_WIDTH  to SRAM port address.
- sram_we  out  1  to SRAM port write-enable.
- sram_wdata  out  DATA_WIDTH  to SRAM port write data.
- sram_q  in  DATA_WIDTH  from SRAM port registered output.

Behaviour:
- Issue (cycle T):
  - The eligible set is req with the bit of the currently acked requestor masked off.
  - The winner is chosen combinationally from the eligible set by round-robin, searching upward from last_grant+1 modulo NUM_REQ.
  - sram_addr, sram_we and sram_wdata are driven from the winner's slices in the same cycle.
  - At the end-of-T edge: last_grant <= winner, pend_valid <= 1, pend_id <= winner.
- Response (cycle T+1):
  - ack[pend_id] = 1 and rdata = sram_q.
  - For a write, rdata is the written data, because the SRAM is write-through.
  - Load-to-response latency is exactly 1 cycle.
- Requestor contract:
  - A requestor holds req, req_we, req_addr and req_wdata stable until it sees its ack.
  - It may present a new request, or drop req, on the edge that ends the ack cycle.
- Masking rule: a requestor is never granted in the same cycle it is being acked. This prevents a duplicate issue of a stale request.
  - Consequence: a single requestor gets at most one access every 2 cycles.
  - Different requestors can be granted back-to-back every cycle.
- Idle cycle (no eligible request):
  - sram_we = 0, sram_addr = 0, sram_wdata = 0.
  - pend_valid <= 0; last_grant is unchanged.
- Ack timing: ack is registered state (pend_valid/pend_id), so all ack bits are 0 in any cycle that follows an idle cycle.
- Fairness: with all NUM_REQ requestors continuously requesting, grants rotate strictly, and every requestor is served within NUM_REQ cycles.
- Reset values (reset_n sampled low at an edge):
  - pend_valid = 0, so ack = 0 the following cycle.
  - last_grant = NUM_REQ-1, so requestor 0 wins first after reset.
  - rdata is combinational from sram_q and carries no meaning without an ack.
- While reset_n is low, sram_we is forced to 0 and no grant is recorded.
- Reset mid-operation: a request issued in the same cycle reset is sampled is discarded and never acked. The requestor must re-present it after reset.
- req_we is ignored for requestors whose req is low.
- Bits of req above NUM_REQ do not exist; the width is exact.

Optional Feature:
- Macro: SRAM_ARB_FIXED_PRIORITY_EN.
- With the macro defined:
  - Arbitration is fixed priority: the lowest index among eligible requestors wins.
  - The last_grant register is removed.
  - The ack-cycle masking rule still applies.
  - Starvation of high indices is acceptable for this build.
- Without the macro: round-robin as described in Behaviour.

Test Plan:
- Reset, then req=0001, we=1, addr=0x010, wdata=0xBEEF:
  - sram_we=1 and sram_addr=0x010 in the same cycle.
  - ack=0001 and rdata=0xBEEF one cycle later.
- After that write, req=0010, we=0, addr=0x010 → ack=0010 and rdata=0xBEEF one cycle after issue.
- req=1111 held, each requestor re-requesting right after its ack:
  - Grant order 0,1,2,3,0,1,...
  - One ack per cycle; no requestor is acked twice within any 4-cycle window.
- Single requestor 2 keeps req high, re-presenting a new address after each ack:
  - Issues in alternate cycles only.
  - ack[2] pulses every second cycle.
  - sram_we is never asserted in the ack cycles.
- Issue a read for requestor 1 and assert reset_n=0 in the same cycle:
  - ack stays 0000 the next cycle and sram_we=0 throughout reset.
  - After release, req=1111 grants requestor 0 first.
- With SRAM_ARB_FIXED_PRIORITY_EN defined and req=0110 held:
  - Grants alternate 1,2,1,2, because the masking rule hands the slot to requestor 2 during requestor 1's ack.
  - Requestor 0, once it requests, wins on the next non-masked cycle.
